uart_reg_bank: RTL and testbench

- Parametrised microcontroller-facing register bank for the UART.
- Buffers transmit bytes in a TX FIFO and sequences them into uart_tx one frame at a time with a launch/done state machine.
- Buffers received bytes in an RX FIFO.
- Provides a live status register and sticky write-1-to-clear (W1C) error/event flags.
- Sits between the CPU bus and the uart_tx/uart_rx cores.

---
 rtl/uart_reg_if.sv | 27 ++
 rtl/uart_reg_bank.sv | 156 +++++++++++++++
 tb/tb_uart_reg_bank.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_reg_if.sv
// uart_reg_if: CPU bus plus uart_tx/uart_rx links of the UART register bank
interface uart_reg_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic              wr_en;
  logic              rd_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [DATA_W-1:0] tx_p_data;
  logic              tx_data_valid;
  logic              tx_busy;
  logic              tx_done;
  logic [DATA_W-1:0] rx_p_data;
  logic              rx_data_valid;
  logic              irq;
  modport master (
    output wr_en, rd_en, addr, wr_data, tx_busy, tx_done, rx_p_data, rx_data_valid,
    input  rd_data, rd_valid, tx_p_data, tx_data_valid, irq
  );
  modport slave (
    input  wr_en, rd_en, addr, wr_data, tx_busy, tx_done, rx_p_data, rx_data_valid,
    output rd_data, rd_valid, tx_p_data, tx_data_valid, irq
  );
endinterface

// File: rtl/uart_reg_bank.sv
// uart_reg_bank: CPU register bank with TX/RX FIFOs, TX launch sequencer and W1C flags; UART_REG_IRQ_EN enables irq
module uart_reg_bank #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 3,
  parameter int FIFO_DEPTH = 4
) (
  input logic       clk,
  input logic       rst,
  uart_reg_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_TXDATA = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_RXDATA = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_FLAGS  = ADDR_W'(4);
`ifdef UART_REG_IRQ_EN
  localparam logic [3:0] CTRL_MASK = 4'hF;
`else
  localparam logic [3:0] CTRL_MASK = 4'h3;
`endif

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} tx_state_t;

  tx_state_t         r_state, w_next;
  logic [3:0]        r_ctrl, r_flags, w_set, w_clr;
  logic [DATA_W-1:0] r_tx_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] r_rx_mem [FIFO_DEPTH];
  logic [PW-1:0]     r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
  logic [CW-1:0]     r_tx_cnt, r_rx_cnt;
  logic [DATA_W-1:0] r_rd_data, r_tx_p_data, w_rd_mux;
  logic              r_rd_valid;
  logic w_wr, w_rd, w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
  logic w_tx_wr, w_tx_push, w_tx_pop, w_launch, w_done_evt;
  logic w_rx_rd, w_rx_pop, w_rx_in, w_rx_push;

  assign w_wr       = bus.wr_en;
  assign w_rd       = bus.rd_en & ~bus.wr_en;
  assign w_tx_empty = r_tx_cnt == '0;
  assign w_tx_full  = r_tx_cnt == CW'(FIFO_DEPTH);
  assign w_rx_empty = r_rx_cnt == '0;
  assign w_rx_full  = r_rx_cnt == CW'(FIFO_DEPTH);
  assign w_tx_wr    = w_wr && bus.addr == A_TXDATA;
  assign w_tx_push  = w_tx_wr & ~w_tx_full;
  assign w_rx_rd    = w_rd && bus.addr == A_RXDATA;
  assign w_rx_pop   = w_rx_rd & ~w_rx_empty;
  assign w_rx_in    = bus.rx_data_valid & r_ctrl[1];
  // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign w_rx_push  = w_rx_in & (~w_rx_full | w_rx_pop);
  assign w_set      = {w_rx_rd & w_rx_empty, w_done_evt, w_rx_in & w_rx_full & ~w_rx_pop, w_tx_wr & w_tx_full};
  assign w_clr      = (w_wr && bus.addr == A_FLAGS) ? bus.wr_data[3:0] : 4'h0;

  assign bus.rd_data       = r_rd_data;
  assign bus.rd_valid      = r_rd_valid;
  assign bus.tx_p_data     = r_tx_p_data;
  assign bus.tx_data_valid = r_state == LAUNCH;

  // TX sequencer next state: launch one byte, then wait for the frame to end
  always_comb begin
    w_next     = r_state;
    w_launch   = 1'b0;
    w_tx_pop   = 1'b0;
    w_done_evt = 1'b0;
    case (r_state)
      IDLE:    if (r_ctrl[0] && !w_tx_empty && !bus.tx_busy) begin
                 w_next   = LAUNCH;
                 w_launch = 1'b1;
               end
      LAUNCH:  begin
                 w_next   = WAIT;
                 w_tx_pop = 1'b1;
               end
      WAIT:    if (bus.tx_done) begin
                 w_next     = IDLE;
                 w_done_evt = 1'b1;
               end
      default: w_next = IDLE;
    endcase
  end

  // TX sequencer state and the byte presented to uart_tx, captured on the way into LAUNCH
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_tx_p_data <= '0;
    end else begin
      r_state <= w_next;
      if (w_launch) r_tx_p_data <= r_tx_mem[r_tx_rp];
    end
  end

  // register read multiplexer
  always_comb begin
    w_rd_mux = '0;
    case (bus.addr)
      A_CTRL:   w_rd_mux = DATA_W'(r_ctrl);
      A_RXDATA: w_rd_mux = w_rx_empty ? '0 : r_rx_mem[r_rx_rp];
      A_STATUS: w_rd_mux = DATA_W'({r_state != IDLE, w_rx_full, w_rx_empty, w_tx_full, w_tx_empty, bus.tx_busy});
      A_FLAGS:  w_rd_mux = DATA_W'(r_flags);
      default:  w_rd_mux = '0;
    endcase
  end

  // CTRL storage, sticky flags (set beats clear) and registered read port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ctrl     <= '0;
      r_flags    <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      if (w_wr && bus.addr == A_CTRL) r_ctrl <= bus.wr_data[3:0] & CTRL_MASK;
      r_flags    <= (r_flags & ~w_clr) | w_set;
      r_rd_valid <= w_rd;
      if (w_rd) r_rd_data <= w_rd_mux;
    end
  end

  // FIFO pointers and counts; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_tx_cnt <= '0;
      r_rx_wp  <= '0;
      r_rx_rp  <= '0;
      r_rx_cnt <= '0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + PW'(1);
      if (w_tx_pop) r_tx_rp <= r_tx_rp + PW'(1);
      r_tx_cnt <= r_tx_cnt + CW'(w_tx_push) - CW'(w_tx_pop);
      if (w_rx_push) r_rx_wp <= r_rx_wp + PW'(1);
      if (w_rx_pop) r_rx_rp <= r_rx_rp + PW'(1);
      r_rx_cnt <= r_rx_cnt + CW'(w_rx_push) - CW'(w_rx_pop);
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wp] <= bus.wr_data;
    if (w_rx_push) r_rx_mem[r_rx_wp] <= bus.rx_p_data;
  end

`ifdef UART_REG_IRQ_EN
  logic r_irq;
  assign bus.irq = r_irq;
  // interrupt request, one cycle behind its causes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_irq <= 1'b0;
    else r_irq <= (r_ctrl[2] & ~w_rx_empty) | (r_ctrl[3] & w_tx_empty & (r_state == IDLE)) | (|r_flags);
  end
`else
  assign bus.irq = 1'b0;
`endif
endmodule

// File: tb/tb_uart_reg_bank.sv
// tb_uart_reg_bank: directed vector bench for uart_reg_bank
module tb_uart_reg_bank;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_reg_if #(.DATA_W(8), .ADDR_W(3)) bus ();
  uart_reg_bank #(.DATA_W(8), .ADDR_W(3), .FIFO_DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef UART_REG_IRQ_EN
  localparam logic [7:0] CTRL_RB = 8'h0F;
  localparam logic       IRQ_ON  = 1'b1;
`else
  localparam logic [7:0] CTRL_RB = 8'h03;
  localparam logic       IRQ_ON  = 1'b0;
`endif

  typedef struct {
    logic [2:0] a;
    logic [7:0] d;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int n_launch = 0;
  int base;
  logic [7:0] d;
  logic got;
  vec_t rv[9];
  logic [7:0] exp_after[4];

  always @(posedge clk) if (bus.tx_data_valid) n_launch++;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] v);
    bus.wr_en = 1'b1;
    bus.addr = a;
    bus.wr_data = v;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [2:0] a, input logic [7:0] exp);
    bus.rd_en = 1'b1;
    bus.addr = a;
    @(negedge clk);
    bus.rd_en = 1'b0;
    check({nm, " rd_valid"}, bus.rd_valid, 1);
    check(nm, bus.rd_data, exp);
  endtask

  task automatic rx_byte(input logic [7:0] v);
    bus.rx_data_valid = 1'b1;
    bus.rx_p_data = v;
    @(negedge clk);
    bus.rx_data_valid = 1'b0;
  endtask

  task automatic wait_launch(output logic g, output logic [7:0] v);
    g = 1'b0;
    v = '0;
    for (int i = 0; i < 50 && !g; i++) begin
      if (bus.tx_data_valid) begin
        g = 1'b1;
        v = bus.tx_p_data;
      end else @(negedge clk);
    end
  endtask

  task automatic tx_done_pulse();
    bus.tx_busy = 1'b0;
    bus.tx_done = 1'b1;
    @(negedge clk);
    bus.tx_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rv = '{'{3'd0, 8'h00}, '{3'd1, 8'h00}, '{3'd3, 8'h0A}, '{3'd4, 8'h00}, '{3'd5, 8'h00},
           '{3'd6, 8'h00}, '{3'd7, 8'h00}, '{3'd2, 8'h00}, '{3'd4, 8'h08}};
    exp_after = '{8'h21, 8'h22, 8'h23, 8'h77};
    bus.wr_en = 0; bus.rd_en = 0; bus.addr = 0; bus.wr_data = 0;
    bus.tx_busy = 0; bus.tx_done = 0; bus.rx_p_data = 0; bus.rx_data_valid = 0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("reset outputs", {bus.rd_data, bus.rd_valid, bus.tx_p_data, bus.tx_data_valid, bus.irq}, 0);
    for (int i = 0; i < 9; i++) rd_chk($sformatf("reset read %0d addr %0d", i, rv[i].a), rv[i].a, rv[i].d);
    @(negedge clk);
    check("rd_valid one cycle", bus.rd_valid, 0);
    wr(3'd4, 8'h08);
    bus.wr_en = 1; bus.rd_en = 1; bus.addr = 0; bus.wr_data = 8'hFF;
    @(negedge clk);
    bus.wr_en = 0; bus.rd_en = 0;
    check("wr priority rd_valid", bus.rd_valid, 0);
    rd_chk("ctrl readback", 3'd0, CTRL_RB);
    wr(3'd0, 8'h00);
    rd_chk("flags clean", 3'd4, 8'h00);

    wr(3'd0, 8'h01);
    wr(3'd1, 8'h55);
    wr(3'd1, 8'hA3);
    wait_launch(got, d);
    check("launch1 seen", got, 1);
    check("launch1 data", d, 8'h55);
    bus.tx_busy = 1'b1;
    @(negedge clk);
    check("launch one cycle", bus.tx_data_valid, 0);
    base = n_launch;
    repeat (5) @(negedge clk);
    check("no launch before done", n_launch - base, 0);
    check("tx_p_data held", bus.tx_p_data, 8'h55);
    tx_done_pulse();
    check("gap after done", bus.tx_data_valid, 0);
    wait_launch(got, d);
    check("launch2 seen", got, 1);
    check("launch2 data", d, 8'hA3);
    bus.tx_busy = 1'b1;
    rd_chk("flags done_seen", 3'd4, 8'h04);
    tx_done_pulse();
    @(negedge clk);
    rd_chk("status after tx", 3'd3, 8'h0A);
    wr(3'd4, 8'h04);
    rd_chk("flags cleared", 3'd4, 8'h00);

    wr(3'd0, 8'h00);
    base = n_launch;
    for (int i = 1; i <= 5; i++) wr(3'd1, 8'(i));
    rd_chk("status tx_full", 3'd3, 8'h0C);
    rd_chk("flags tx_overflow", 3'd4, 8'h01);
    check("no launch tx_en=0", n_launch - base, 0);
    wr(3'd4, 8'h00);
    rd_chk("flags write0 no effect", 3'd4, 8'h01);
    wr(3'd4, 8'h01);
    rd_chk("flags w1c", 3'd4, 8'h00);

    rx_byte(8'h99);
    rd_chk("rx ignored rx_en=0", 3'd3, 8'h0C);
    wr(3'd0, 8'h02);
    for (int i = 0; i < 5; i++) rx_byte(8'h10 + 8'(i));
    for (int i = 0; i < 4; i++) rd_chk($sformatf("rx pop %0d", i), 3'd2, 8'h10 + 8'(i));
    rd_chk("rx empty read", 3'd2, 8'h00);
    rd_chk("rx flags", 3'd4, 8'h0A);
    wr(3'd4, 8'h0A);

    for (int i = 0; i < 4; i++) rx_byte(8'h20 + 8'(i));
    rd_chk("status rx_full", 3'd3, 8'h14);
    bus.rx_data_valid = 1; bus.rx_p_data = 8'h77; bus.rd_en = 1; bus.addr = 3'd2;
    @(negedge clk);
    bus.rx_data_valid = 0; bus.rd_en = 0;
    check("simul pop head", bus.rd_data, 8'h20);
    rd_chk("simul still full", 3'd3, 8'h14);
    rd_chk("simul no overrun", 3'd4, 8'h00);
    for (int i = 0; i < 4; i++) rd_chk($sformatf("rx after simul %0d", i), 3'd2, exp_after[i]);

    wr(3'd0, 8'h01);
    wait_launch(got, d);
    check("launch3 data", {got, d}, {1'b1, 8'h01});
    bus.tx_busy = 1'b1;
    @(negedge clk);
    rd_chk("status in wait", 3'd3, 8'h29);
    wr(3'd0, 8'h00);
    tx_done_pulse();
    base = n_launch;
    repeat (5) @(negedge clk);
    check("no launch after tx_en cleared", n_launch - base, 0);
    rd_chk("done after tx_en cleared", 3'd4, 8'h04);
    wr(3'd4, 8'h04);

    wr(3'd0, 8'h01);
    wait_launch(got, d);
    check("launch4 data", {got, d}, {1'b1, 8'h02});
    bus.tx_busy = 1'b1;
    repeat (2) @(negedge clk);
    check("tx_p_data in wait", bus.tx_p_data, 8'h02);
    #2 rst = 1'b0;
    #1;
    check("async rst tx_p_data", bus.tx_p_data, 8'h00);
    check("async rst tx_data_valid", bus.tx_data_valid, 0);
    @(negedge clk);
    bus.tx_busy = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rd_chk("status after rst", 3'd3, 8'h0A);
    rd_chk("ctrl after rst", 3'd0, 8'h00);
    rd_chk("flags after rst", 3'd4, 8'h00);
    wr(3'd0, 8'h01);
    base = n_launch;
    repeat (5) @(negedge clk);
    check("tx fifo flushed", n_launch - base, 0);

    wr(3'd0, 8'h06);
    @(negedge clk);
    check("irq quiet", bus.irq, 0);
    rx_byte(8'h42);
    check("irq not same cycle", bus.irq, 0);
    @(negedge clk);
    check("irq after rx push", bus.irq, IRQ_ON);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
